// File: rtl/prl_pkg.sv
// Shared encodings for the protocol-layer RX message interface.
// Covers field widths, message classes, info bit positions and FSM states.
package prl_pkg;

  localparam int MSG_CLASS_W = 2;
  localparam int HDR_TYPE_W  = 5;
  localparam int RX_TYPE_W   = MSG_CLASS_W + HDR_TYPE_W;
  localparam int SOP_W       = 3;
  localparam int INFO_W      = 9;
  localparam int WORD_W      = RX_TYPE_W + SOP_W + INFO_W;
  localparam int CNT_W       = 10;

  localparam logic [MSG_CLASS_W-1:0] MSG_CLASS_CTRL = 2'b00;
  localparam logic [MSG_CLASS_W-1:0] MSG_CLASS_DATA = 2'b01;
  localparam logic [MSG_CLASS_W-1:0] MSG_CLASS_EXT  = 2'b10;

  // Positions inside the opaque info field, as decoded by the RX state machine
  localparam int INFO_MSG_ID_LSB   = 0;
  localparam int INFO_MSG_ID_W     = 3;
  localparam int INFO_NUM_DO_LSB   = 3;
  localparam int INFO_NUM_DO_W     = 3;
  localparam int INFO_CHUNKED_BIT  = 6;
  localparam int INFO_PWR_ROLE_BIT = 7;
  localparam int INFO_DATA_ROLE_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } rx_state_e;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [MSG_CLASS_W-1:0] cls,
    input logic [HDR_TYPE_W-1:0]  hdr,
    input logic [SOP_W-1:0]       sop,
    input logic [INFO_W-1:0]      info
  );
    return {cls, hdr, sop, info};
  endfunction

endpackage

// File: rtl/prl_rx_msg_fifo.sv
// Two-entry message buffer with wrap-around 1-bit pointers and a 2-bit count.
// Push/pop are pre-qualified by the caller; discard flushes with top priority.
module prl_rx_msg_fifo
  import prl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              discard,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic [1:0]        count,
  output logic              full
);

  logic [WORD_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count_nxt;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 2'd1;
    else if (!push && pop)
      count_nxt = count - 2'd1;
  end

  // When full, push+pop writes the slot being vacated; the read happens first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      full   <= 1'b0;
    end else if (discard) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      full   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count_nxt;
      full  <= (count_nxt == 2'd2);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/prl_rx_message_if.sv
// Hands received messages to the policy engine one at a time with an ack timeout.
// state   | meaning
// IDLE    | buffer empty, nothing presented
// PRESENT | head entry driven to policy engine, waiting for ack or timeout
// GAP     | one-cycle idle after a pop before the next message is presented
module prl_rx_message_if
  import prl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT_CYC = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prl_rx_st_message_en,
  input  logic [MSG_CLASS_W-1:0] prl_rx_st_message_type,
  input  logic [HDR_TYPE_W-1:0]  prl_rx_st_header_type,
  input  logic [SOP_W-1:0]       prl_rx_st_sop_type,
  input  logic [INFO_W-1:0]      prl_rx_st_info,
  input  logic                   prl_rx_if_discard,
  output logic                   prl_rx_if_full,
  output logic                   prl_rx_if_overflow,
  output logic                   prl_rx_if_timeout,
  output logic                   pl2pe_rx_en,
  output logic [RX_TYPE_W-1:0]   pl2pe_rx_type,
  output logic [SOP_W-1:0]       pl2pe_rx_sop_type,
  output logic [INFO_W-1:0]      pl2pe_rx_info,
  input  logic                   pe2pl_rx_ack
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT_CYC - 1);

  rx_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_in;
  logic [WORD_W-1:0] head;
  logic [1:0]        count;
  logic              ack_ok;
  logic              tmo_hit;
  logic              pop;
  logic              push;
  logic              drop;

  assign word_in = pack_word(prl_rx_st_message_type, prl_rx_st_header_type,
                             prl_rx_st_sop_type, prl_rx_st_info);

  assign ack_ok  = (state == ST_PRESENT) && pe2pl_rx_ack;
  assign tmo_hit = (state == ST_PRESENT) && !pe2pl_rx_ack && (cnt == TMO_LAST);
  assign pop     = !prl_rx_if_discard && (ack_ok || tmo_hit);
  assign push    = !prl_rx_if_discard && prl_rx_st_message_en && ((count != 2'd2) || pop);
  assign drop    = !prl_rx_if_discard && prl_rx_st_message_en && (count == 2'd2) && !pop;

  prl_rx_msg_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .discard (prl_rx_if_discard),
    .push    (push),
    .pop     (pop),
    .wdata   (word_in),
    .rdata   (head),
    .count   (count),
    .full    (prl_rx_if_full)
  );

  // From IDLE with an empty buffer the incoming word is presented directly,
  // so the policy engine sees it one cycle after message_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      word_q             <= '0;
      pl2pe_rx_en        <= 1'b0;
      prl_rx_if_overflow <= 1'b0;
      prl_rx_if_timeout  <= 1'b0;
    end else begin
      prl_rx_if_overflow <= drop;
      prl_rx_if_timeout  <= tmo_hit && !prl_rx_if_discard;
      if (prl_rx_if_discard) begin
        state       <= ST_IDLE;
        cnt         <= '0;
        word_q      <= '0;
        pl2pe_rx_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (count != 2'd0) begin
              state       <= ST_PRESENT;
              word_q      <= head;
              pl2pe_rx_en <= 1'b1;
              cnt         <= '0;
            end else if (push) begin
              state       <= ST_PRESENT;
              word_q      <= word_in;
              pl2pe_rx_en <= 1'b1;
              cnt         <= '0;
            end
          end
          ST_PRESENT: begin
            if (pop) begin
              state       <= ST_GAP;
              word_q      <= '0;
              pl2pe_rx_en <= 1'b0;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
          ST_GAP: begin
            if (count != 2'd0) begin
              state       <= ST_PRESENT;
              word_q      <= head;
              pl2pe_rx_en <= 1'b1;
              cnt         <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state       <= ST_IDLE;
            word_q      <= '0;
            pl2pe_rx_en <= 1'b0;
            cnt         <= '0;
          end
        endcase
      end
    end
  end

  assign pl2pe_rx_type     = word_q[WORD_W-1 -: RX_TYPE_W];
  assign pl2pe_rx_sop_type = word_q[INFO_W +: SOP_W];
  assign pl2pe_rx_info     = word_q[INFO_W-1:0];

endmodule

// File: tb/tb_prl_rx_message_if.sv
// Scoreboard bench: stimulus queues expected deliveries, a monitor checks them.
module tb_prl_rx_message_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       msg_en = 1'b0;
  logic [1:0] mtype = '0;
  logic [4:0] htype = '0;
  logic [2:0] sop = '0;
  logic [8:0] info = '0;
  logic       discard = 1'b0;
  logic       ack = 1'b0;
  logic       full, ovf, tmo, en;
  logic [6:0] rx_type;
  logic [2:0] rx_sop;
  logic [8:0] rx_info;

  int tests = 0;
  int fails = 0;
  logic [18:0] exp_q[$];
  logic [18:0] held;
  logic [18:0] got;
  logic [18:0] want;
  logic        en_prev = 1'b0;

  prl_rx_message_if #(.ACK_TIMEOUT_CYC(8)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .prl_rx_st_message_en   (msg_en),
    .prl_rx_st_message_type (mtype),
    .prl_rx_st_header_type  (htype),
    .prl_rx_st_sop_type     (sop),
    .prl_rx_st_info         (info),
    .prl_rx_if_discard      (discard),
    .prl_rx_if_full         (full),
    .prl_rx_if_overflow     (ovf),
    .prl_rx_if_timeout      (tmo),
    .pl2pe_rx_en            (en),
    .pl2pe_rx_type          (rx_type),
    .pl2pe_rx_sop_type      (rx_sop),
    .pl2pe_rx_info          (rx_info),
    .pe2pl_rx_ack           (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] t, input logic [2:0] s, input logic [8:0] i,
                      input bit deliver);
    msg_en = 1'b1;
    mtype  = t[6:5];
    htype  = t[4:0];
    sop    = s;
    info   = i;
    if (deliver) exp_q.push_back({t, s, i});
    tick();
    msg_en = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Monitor: every presentation must match the queue head and hold steady.
  always @(negedge clk) begin
    got = {rx_type, rx_sop, rx_info};
    if (rst_n) begin
      if (en && !en_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", 32'(got), 32'h7ffff);
        end else begin
          want = exp_q.pop_front();
          check("deliver", 32'(got), 32'(want));
        end
        held = got;
      end else if (en) begin
        check("stable", 32'(got), 32'(held));
      end else begin
        check("idle_zero", 32'(got), 32'h0);
      end
      en_prev = en;
    end else begin
      en_prev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_en", 32'(en), 0);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_tmo", 32'(tmo), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single message, ack
    send(7'h23, 3'd0, 9'h005, 1'b1);
    check("s_en", 32'(en), 1);
    check("s_type", 32'(rx_type), 32'h23);
    check("s_sop", 32'(rx_sop), 0);
    check("s_info", 32'(rx_info), 32'h005);
    tick(); tick();
    check("s_hold_en", 32'(en), 1);
    do_ack();
    check("s_ack_en", 32'(en), 0);
    tick();
    check("s_idle_en", 32'(en), 0);
    check("s_idle_full", 32'(full), 0);

    // three back-to-back, third overflows; ack in GAP is ignored
    send(7'h01, 3'd1, 9'h001, 1'b1);
    check("b_full1", 32'(full), 0);
    send(7'h42, 3'd2, 9'h0aa, 1'b1);
    check("b_full2", 32'(full), 1);
    send(7'h0f, 3'd3, 9'h1ff, 1'b0);
    check("b_ovf", 32'(ovf), 1);
    tick();
    check("b_ovf_pulse", 32'(ovf), 0);
    check("b_full_hold", 32'(full), 1);
    ack = 1'b1;
    tick();
    check("b_gap_en", 32'(en), 0);
    check("b_gap_full", 32'(full), 0);
    tick();
    ack = 1'b0;
    check("b_second_en", 32'(en), 1);
    tick();
    check("b_gap_ack_ignored", 32'(en), 1);
    do_ack();
    check("b_done_en", 32'(en), 0);
    tick(); tick();
    check("b_idle_en", 32'(en), 0);

    // full plus message_en and ack in the same cycle
    send(7'h21, 3'd4, 9'h011, 1'b1);
    send(7'h22, 3'd5, 9'h022, 1'b1);
    msg_en = 1'b1; mtype = 2'b10; htype = 5'h03; sop = 3'd6; info = 9'h133;
    exp_q.push_back({7'h43, 3'd6, 9'h133});
    ack = 1'b1;
    tick();
    msg_en = 1'b0; ack = 1'b0;
    check("f_no_ovf", 32'(ovf), 0);
    check("f_full", 32'(full), 1);
    check("f_gap_en", 32'(en), 0);
    tick();
    check("f_b_en", 32'(en), 1);
    do_ack();
    tick();
    check("f_c_en", 32'(en), 1);
    check("f_c_full", 32'(full), 0);
    do_ack();
    tick(); tick();

    // timeout drops the head, next message follows
    send(7'h05, 3'd1, 9'h050, 1'b1);
    send(7'h06, 3'd2, 9'h060, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check("t_wait_tmo", 32'(tmo), 0);
      tick();
    end
    check("t_cyc8_en", 32'(en), 1);
    tick();
    check("t_tmo", 32'(tmo), 1);
    check("t_tmo_en", 32'(en), 0);
    tick();
    check("t_tmo_pulse", 32'(tmo), 0);
    check("t_next_en", 32'(en), 1);
    do_ack();
    tick(); tick();

    // ack on the expiry cycle wins
    send(7'h07, 3'd3, 9'h070, 1'b1);
    for (int k = 0; k < 7; k++) tick();
    check("a_cyc8_en", 32'(en), 1);
    do_ack();
    check("a_no_tmo", 32'(tmo), 0);
    check("a_en", 32'(en), 0);
    tick();
    check("a_no_tmo2", 32'(tmo), 0);
    tick();

    // discard while full with message_en in the same cycle
    send(7'h08, 3'd0, 9'h080, 1'b1);
    send(7'h09, 3'd1, 9'h090, 1'b0);
    check("d_full_before", 32'(full), 1);
    discard = 1'b1;
    msg_en = 1'b1; mtype = 2'b00; htype = 5'h0a; sop = 3'd2; info = 9'h0a0;
    tick();
    discard = 1'b0; msg_en = 1'b0;
    check("d_en", 32'(en), 0);
    check("d_full", 32'(full), 0);
    check("d_ovf", 32'(ovf), 0);
    tick();
    check("d_ovf2", 32'(ovf), 0);
    check("d_en2", 32'(en), 0);
    tick();
    check("d_en3", 32'(en), 0);

    // reset mid-handshake
    send(7'h0b, 3'd3, 9'h0b0, 1'b1);
    send(7'h0c, 3'd4, 9'h0c0, 1'b0);
    check("r_en_before", 32'(en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("r_en", 32'(en), 0);
    check("r_full", 32'(full), 0);
    check("r_type", 32'(rx_type), 0);
    check("r_info", 32'(rx_info), 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("r_post_en", 32'(en), 0);
      check("r_post_tmo", 32'(tmo), 0);
    end
    send(7'h2d, 3'd5, 9'h0d0, 1'b1);
    check("r_new_en", 32'(en), 1);
    do_ack();
    tick(); tick();

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
